// File: rtl/rule_conf_arbiter_pkg.sv
// Shared parser rule-config definitions: commit-address decode, arbiter
// FSM states and the commit-beat classifier.
package rule_conf_arbiter_pkg;

  // A commit beat has address bit 16 set and address field [10:8] equal to 0.
  localparam int         COMMIT_BIT       = 16;
  localparam int         COMMIT_FIELD_HI  = 10;
  localparam int         COMMIT_FIELD_LO  = 8;
  localparam logic [2:0] COMMIT_FIELD_VAL = 3'd0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_GAP   = 2'd2
  } arb_state_e;

  function automatic logic is_commit(input logic [31:0] addr);
    return addr[COMMIT_BIT] &&
           (addr[COMMIT_FIELD_HI:COMMIT_FIELD_LO] == COMMIT_FIELD_VAL);
  endfunction

endpackage

// File: rtl/rule_conf_arbiter_rr_arbiter.sv
// Combinational round-robin pick: the first set request at or above the
// pointer wins, otherwise the first set request wrapping from index 0.
// Produces a one-hot winner and its index (both zero when nothing requests).
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_grant_oh,
  output logic [IW-1:0] o_grant_idx
);

  logic found;

  // Two-pass scan: upper segment [ptr..N-1] first, then wrap to [0..ptr-1].
  always_comb begin
    o_grant_oh  = '0;
    o_grant_idx = '0;
    found       = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && i_req[i] && (IW'(i) >= i_ptr)) begin
        found         = 1'b1;
        o_grant_oh[i] = 1'b1;
        o_grant_idx   = IW'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!found && i_req[i]) begin
        found         = 1'b1;
        o_grant_oh[i] = 1'b1;
        o_grant_idx   = IW'(i);
      end
    end
  end

endmodule

// File: rtl/rule_conf_arbiter.sv
// Rule-configuration write arbiter. Several masters share the parser's single
// rule-config write port. A grant is locked for a whole burst so multi-word
// rule programming is never interleaved; commit writes are followed by idle
// gap cycles so the rule table settles; a stalled burst is force-released.
//
// Handshake: a beat transfers on a clock edge where i_req_valid[k] and
// o_req_ready[k] are both high. The requester holds valid/addr/wdata/last
// stable until accepted. o_req_ready is one-hot or zero, is a function of
// the registered state and grant only, and never looks at any valid input.
module rule_conf_arbiter
  import rule_conf_arbiter_pkg::*;
#(
  parameter  int REQ_NUM    = 2,
  parameter  int GAP_CYCLES = 2,
  parameter  int TIMEOUT    = 255,
  localparam int GW         = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [REQ_NUM-1:0]       i_req_valid,
  input  logic [REQ_NUM-1:0]       i_req_last,
  input  logic [REQ_NUM-1:0][31:0] i_req_addr,
  input  logic [REQ_NUM-1:0][31:0] i_req_wdata,
  output logic [REQ_NUM-1:0]       o_req_ready,
  output logic                     o_rule_wren,
  output logic [31:0]              o_rule_addr,
  output logic [31:0]              o_rule_wdata,
  output logic [GW-1:0]            o_grant_id,
  output logic                     o_busy,
  output logic                     o_timeout,
  output logic [15:0]              o_commit_cnt,
  output logic [1:0]               o_dbg_state
);

  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int PW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TO_LAST  = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [PW-1:0] GAP_LAST = PW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [GW-1:0] LAST_ID  = GW'(REQ_NUM - 1);

  arb_state_e    state_q, state_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [GW-1:0] ptr_q, ptr_d;
  logic          wren_q, wren_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          timeout_q, timeout_d;
  logic [15:0]   commit_cnt_q, commit_cnt_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [PW-1:0] gap_cnt_q, gap_cnt_d;
  logic          gap_last_q, gap_last_d;

  logic [REQ_NUM-1:0] win_oh;
  logic [GW-1:0]      win_idx;
  logic               any_win;
  logic               sel_valid;
  logic               sel_last;
  logic [31:0]        sel_addr;
  logic [31:0]        sel_wdata;
  logic [GW-1:0]      next_ptr;

  rr_arbiter #(
    .N  (REQ_NUM),
    .IW (GW)
  ) u_rr (
    .i_req       (i_req_valid),
    .i_ptr       (ptr_q),
    .o_grant_oh  (win_oh),
    .o_grant_idx (win_idx)
  );

  assign any_win   = |win_oh;
  assign sel_valid = i_req_valid[grant_q];
  assign sel_last  = i_req_last[grant_q];
  assign sel_addr  = i_req_addr[grant_q];
  assign sel_wdata = i_req_wdata[grant_q];
  // Round-robin pointer moves to the requester after the one just served.
  assign next_ptr  = (grant_q == LAST_ID) ? '0 : grant_q + GW'(1);

  // Next-state, grant lock, write-port load, gap and timeout counting.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    ptr_d        = ptr_q;
    wren_d       = 1'b0;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    timeout_d    = 1'b0;
    commit_cnt_d = commit_cnt_q;
    to_cnt_d     = to_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    gap_last_d   = gap_last_q;
    unique case (state_q)
      ST_IDLE: begin
        to_cnt_d = '0;
        if (any_win) begin
          grant_d = win_idx;
          state_d = ST_BURST;
        end
      end
      ST_BURST: begin
        if (sel_valid) begin
          wren_d   = 1'b1;
          addr_d   = sel_addr;
          wdata_d  = sel_wdata;
          to_cnt_d = '0;
          if (is_commit(sel_addr)) begin
            commit_cnt_d = commit_cnt_q + 16'd1;
            if (GAP_CYCLES > 0) begin
              state_d    = ST_GAP;
              gap_cnt_d  = '0;
              gap_last_d = sel_last;
            end else if (sel_last) begin
              state_d = ST_IDLE;
              ptr_d   = next_ptr;
            end
          end else if (sel_last) begin
            state_d = ST_IDLE;
            ptr_d   = next_ptr;
          end
        end else if (TIMEOUT > 0) begin
          // Granted requester is silent: count toward a forced release.
          if (to_cnt_q == TO_LAST) begin
            timeout_d = 1'b1;
            to_cnt_d  = '0;
            state_d   = ST_IDLE;
            ptr_d     = next_ptr;
          end else begin
            to_cnt_d = to_cnt_q + TW'(1);
          end
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          gap_cnt_d = '0;
          if (gap_last_q) begin
            state_d = ST_IDLE;
            ptr_d   = next_ptr;
          end else begin
            state_d = ST_BURST;
          end
        end else begin
          gap_cnt_d = gap_cnt_q + PW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; asynchronous reset clears everything.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      ptr_q        <= '0;
      wren_q       <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      timeout_q    <= 1'b0;
      commit_cnt_q <= '0;
      to_cnt_q     <= '0;
      gap_cnt_q    <= '0;
      gap_last_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      ptr_q        <= ptr_d;
      wren_q       <= wren_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      timeout_q    <= timeout_d;
      commit_cnt_q <= commit_cnt_d;
      to_cnt_q     <= to_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      gap_last_q   <= gap_last_d;
    end
  end

  // Ready only to the locked requester, and only while in a burst.
  always_comb begin
    o_req_ready = '0;
    if (state_q == ST_BURST) o_req_ready[grant_q] = 1'b1;
  end

  assign o_rule_wren  = wren_q;
  assign o_rule_addr  = addr_q;
  assign o_rule_wdata = wdata_q;
  assign o_grant_id   = grant_q;
  assign o_busy       = (state_q != ST_IDLE);
  assign o_timeout    = timeout_q;
  assign o_commit_cnt = commit_cnt_q;
  assign o_dbg_state  = state_q;

endmodule

// File: doc/rule_conf_arbiter.md
Name: rule_conf_arbiter

Overview:
Arbitrates parser rule-configuration writes from REQ_NUM masters (host CSR bridge, boot-time rule loader, and others) onto the single rule-config write port of the parser.
- Round-robin grant; the grant is locked for a whole burst so multi-word rule programming (type data/mask, key offsets, shifts, then commit) is never interleaved.
- After every rule-commit write, idle gap cycles are inserted so the downstream rule table settles.
- A timeout releases a stalled burst.

Parameters:
REQ_NUM, 2, number of requesters (1..8)
GAP_CYCLES, 2, idle cycles inserted after each commit write (0 = none)
TIMEOUT, 255, idle cycles tolerated mid-burst before the lock is released (0 = disabled)

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous, active-low reset
i_req_valid  in  REQ_NUM  per-requester write request
i_req_last  in  REQ_NUM  marks final beat of a burst
i_req_addr  in  REQ_NUM x 32  per-requester config address
i_req_wdata  in  REQ_NUM x 32  per-requester config data
o_req_ready  out  REQ_NUM  per-requester accept
o_rule_wren  out  1  registered write strobe to parser rule-config port
o_rule_addr  out  32  registered address
o_rule_wdata  out  32  registered data
o_grant_id  out  $clog2(REQ_NUM) (min 1)  current/last granted requester
o_busy  out  1  state != IDLE
o_timeout  out  1  one-cycle pulse when a burst is force-released
o_commit_cnt  out  16  count of commit writes issued, wraps at 16'hFFFF->0

Behaviour:
- Reset values: all outputs 0; state IDLE; round-robin pointer 0; counters 0.
- Handshake: a beat transfers when i_req_valid[k] & o_req_ready[k]. The requester holds valid/addr/wdata/last stable until ready. At most one ready bit is high per cycle; ready never depends on the same-cycle valid of another requester.
- Commit beat: addr[16]==1 && addr[10:8]==3'd0. All other addresses are ordinary config writes.
- States:
  - IDLE: if any valid, grant the first valid requester scanning from the pointer upward, modulo REQ_NUM. Register o_grant_id and go to BURST. No ready is asserted in IDLE.
  - BURST: o_req_ready[grant] = 1.
    - On a transfer: o_rule_wren/addr/wdata are loaded next cycle for exactly one cycle, and the timeout counter is cleared.
    - Commit beat with GAP_CYCLES>0: go to GAP; increment o_commit_cnt.
    - Else if last: go to IDLE; pointer = grant+1 mod REQ_NUM.
    - No valid: the timeout counter increments. When it reaches TIMEOUT, pulse o_timeout and go to IDLE with the pointer advanced.
  - GAP: ready is 0. Count GAP_CYCLES cycles, then return to BURST if the commit beat was not last, else go to IDLE with the pointer advanced. The grant is held throughout GAP.
- Commit with GAP_CYCLES==0: o_commit_cnt still increments, and last/non-last handling is as in BURST.
- Latency: valid in IDLE at cycle 0 -> ready at cycle 1 -> o_rule_wren at cycle 2. Back-to-back beats in BURST give one wren per cycle.
- o_rule_addr/o_rule_wdata hold their last value when wren is 0.
- Timeout counter width is $clog2(TIMEOUT+1). It counts only in BURST with no valid from the granted requester.
- A requester that deasserts valid mid-burst keeps the lock until the timeout fires. It is not an error below TIMEOUT.
- Reset mid-burst returns to IDLE immediately; no partial wren is emitted after reset.
- REQ_NUM==1: the pointer stays 0; the FSM is otherwise unchanged.

Decomposition:
- Shared parser config package holds:
  - commit-address decode constants (bit 16, field [10:8], value 0);
  - state enum {IDLE, BURST, GAP};
  - a function is_commit(addr).
- One natural sub-module: rr_arbiter. Combinational first-set scan from the pointer, giving a one-hot winner plus its index; reused by other parser schedulers.

Test Plan:
- Single write: requester 0 sends one beat, addr=32'h0000_0002, wdata=5, last=1 -> wren at cycle 2 with addr 2/data 5; back to IDLE; pointer=1.
- Atomic burst: req0 sends 4-beat burst (typeData, keyOffset, headShift, commit 32'h0001_0003 with last) while req1 is valid throughout -> 4 consecutive req0 wrens. With GAP_CYCLES=2, 2 idle cycles follow, then req1 is granted; o_commit_cnt=1.
- Fairness: both requesters continuously send single-beat bursts -> grants alternate 0,1,0,1; no requester is starved.
- Mid-burst commit: a commit on beat 2 of a 3-beat burst -> 2-cycle gap, grant held, beat 3 follows; the other requester is not interleaved.
- Timeout: with TIMEOUT=4, req1 drops valid after beat 1 of a non-last burst -> o_timeout pulses after 4 idle cycles; req0 is granted next.
- Reset mid-burst: assert i_rst_n low during BURST -> all outputs 0 asynchronously; after release, no stale wren appears and the pointer is 0.
